// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM
// states and the index-width helper.
package nibble_serial_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(width/NIBBLE_W)), never less than one bit
  function automatic int idx_width(input int width);
    int n;
    int w;
    n = width / NIBBLE_W;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
interface nibble_serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/nibble_serial_sub_sub_slice4.sv
// Combinational 4-bit a + ~b + cin with generate/propagate lookahead carry.
module sub_slice4
  import nibble_serial_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W-1:0] bn;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    bn = ~b;
    g  = a & bn;
    p  = a ^ bn;
    // carries flattened so no bit waits on a ripple through its neighbours
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIBBLE_W-1:0];
    cout = c[NIBBLE_W];
  end
endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: one nibble of a - b per clock, LSB nibble first,
// borrow chain held in a carry register between nibbles.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  nibble_serial_sub_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    diff_reg;
  logic [WIDTH-1:0]    next_diff;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic                borrow_reg;
  logic                zero_reg;
  logic                ovf_reg;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s;
  logic                cout;
  logic                last;

  sub_slice4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_comb begin
    a_nib     = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
    b_nib     = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
    last      = (idx == LAST_IDX);
    next_diff = diff_reg;
    next_diff[NIBBLE_W*int'(idx) +: NIBBLE_W] = s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = RUN;
      RUN:     if (last)         next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      idx        <= '0;
      carry      <= 1'b1;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            diff_reg <= '0;
            idx      <= '0;
            carry    <= 1'b1;
          end
        end
        RUN: begin
          diff_reg <= next_diff;
          carry    <= cout;
          // flags are resolved on the final nibble, as the result is committed
          if (last) begin
            idx        <= '0;
            borrow_reg <= ~cout;
            zero_reg   <= (next_diff == '0);
            ovf_reg    <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                          (s[NIBBLE_W-1] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.zero      = zero_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub: WIDTH=16 and WIDTH=4 instances checked
// against an arithmetic reference model.
module tb_nibble_serial_sub;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  nibble_serial_sub_if #(.WIDTH(16)) bus16 ();
  nibble_serial_sub_if #(.WIDTH(4))  bus4 ();

  nibble_serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  nibble_serial_sub #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a - b computed from signed/unsigned integer arithmetic over w bits
  function automatic res_t modelRef(input int w, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    longint m, ua, ub, sa, sb, sd, half;
    m    = (64'sd1 << w);
    half = m / 2;
    ua   = longint'(a) % m;
    ub   = longint'(b) % m;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    sd   = sa - sb;
    r.diff   = 16'((ua - ub + m) % m);
    r.borrow = (ua < ub);
    r.zero   = (ua == ub);
    r.ovf    = (sd < -half) || (sd >= half);
    return r;
  endfunction

  function automatic logic curInReady(input bit narrow);
    return narrow ? bus4.in_ready : bus16.in_ready;
  endfunction

  function automatic logic curOutValid(input bit narrow);
    return narrow ? bus4.out_valid : bus16.out_valid;
  endfunction

  function automatic logic [15:0] curDiff(input bit narrow);
    return narrow ? {12'h000, bus4.diff} : bus16.diff;
  endfunction

  function automatic logic [2:0] curFlags(input bit narrow);
    return narrow ? {bus4.borrow, bus4.zero, bus4.ovf}
                  : {bus16.borrow, bus16.zero, bus16.ovf};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setInputs(input bit narrow, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (narrow) begin
      bus4.in_valid = v;
      bus4.a        = a[3:0];
      bus4.b        = b[3:0];
    end else begin
      bus16.in_valid = v;
      bus16.a        = a;
      bus16.b        = b;
    end
  endtask

  task automatic setOutReady(input bit narrow, input logic v);
    if (narrow) bus4.out_ready = v;
    else        bus16.out_ready = v;
  endtask

  // one full transaction; hold keeps out_ready low for that many cycles
  task automatic applyStimulus(input bit narrow, input logic [15:0] a, input logic [15:0] b,
                               input int hold, input bit pulseNew);
    int   w;
    int   lat;
    int   waitCnt;
    res_t exp;
    w   = narrow ? 4 : 16;
    exp = modelRef(w, a, b);
    waitCnt = 0;
    while (!curInReady(narrow) && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready_before_accept", 32'(curInReady(narrow)), 32'd1);
    setInputs(narrow, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    setInputs(narrow, 1'b0, 16'($urandom), 16'($urandom));
    lat = 0;
    while (!curOutValid(narrow) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(w / 4));
    checkOutput("diff", 32'(curDiff(narrow)), 32'(exp.diff));
    checkOutput("borrow_zero_ovf", 32'(curFlags(narrow)), 32'({exp.borrow, exp.zero, exp.ovf}));
    for (int i = 0; i < hold; i++) begin
      if (pulseNew) setInputs(narrow, 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(curOutValid(narrow)), 32'd1);
      checkOutput("hold_diff", 32'(curDiff(narrow)), 32'(exp.diff));
      checkOutput("hold_in_ready", 32'(curInReady(narrow)), 32'd0);
    end
    setInputs(narrow, 1'b0, 16'h0000, 16'h0000);
    setOutReady(narrow, 1'b1);
    @(negedge clk);
    setOutReady(narrow, 1'b0);
    checkOutput("release_out_valid", 32'(curOutValid(narrow)), 32'd0);
    checkOutput("release_in_ready", 32'(curInReady(narrow)), 32'd1);
  endtask

  initial begin
    bit seenValid;
    assertCount = 0;
    failCount   = 0;
    rst_n = 1'b0;
    setInputs(1'b0, 1'b0, 16'h0000, 16'h0000);
    setInputs(1'b1, 1'b0, 16'h0000, 16'h0000);
    setOutReady(1'b0, 1'b0);
    setOutReady(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("reset_diff", 32'(bus16.diff), 32'd0);
    checkOutput("reset_flags", 32'({bus16.borrow, bus16.zero, bus16.ovf}), 32'd0);
    checkOutput("reset_in_ready_w4", 32'(bus4.in_ready), 32'd1);
    checkOutput("reset_out_valid_w4", 32'(bus4.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 16'h1234, 16'h0234, 0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0001, 0, 1'b0);
    applyStimulus(1'b0, 16'h8000, 16'h0001, 0, 1'b0);
    applyStimulus(1'b0, 16'h5A5A, 16'h5A5A, 0, 1'b0);
    applyStimulus(1'b0, 16'h7FFF, 16'hFFFF, 0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0, 1'b0);
    $display("[TB] backpressure with ignored in_valid pulses");
    applyStimulus(1'b0, 16'h1234, 16'h0234, 10, 1'b1);

    $display("[TB] reset during RUN");
    setInputs(1'b0, 1'b1, 16'h1234, 16'h0234);
    @(posedge clk);
    @(negedge clk);
    setInputs(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrun_in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("midrun_out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("midrun_diff", 32'(bus16.diff), 32'd0);
    seenValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus16.out_valid) seenValid = 1'b1;
    end
    checkOutput("midrun_no_out_valid", 32'(seenValid), 32'd0);
    applyStimulus(1'b0, 16'h0003, 16'h0005, 0, 1'b0);

    $display("[TB] WIDTH=4 instance");
    applyStimulus(1'b1, 16'h0003, 16'h0005, 0, 1'b0);
    applyStimulus(1'b1, 16'h0008, 16'h0001, 0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 2, 1'b1);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle two's-complement subtractor: diff = a - b over WIDTH bits, one 4-bit nibble per clock, LSB nibble first.
- Borrow is registered between nibbles.
- Serves as the low-area subtract path beside the 4-bit carry-lookahead adder slices in the arithmetic datapath.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands a and b are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer takes the result
- diff  output  WIDTH  a - b, modulo 2^WIDTH
- borrow  output  1  unsigned borrow, 1 when a < b unsigned
- zero  output  1  1 when diff == 0
- ovf  output  1  signed overflow of a - b

Behaviour:
- Reset: rst_n low at a rising clk edge sets:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - diff, borrow, zero and ovf all 0
  - nibble index = 0
  - internal carry = 1
- Reset takes priority over all other events. A reset during RUN or DONE discards the operation; no out_valid is produced for it.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a and b into a_reg and b_reg, clear diff, set index = 0, set carry = 1, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle computes {c, s} = a_reg[4k+3:4k] + ~b_reg[4k+3:4k] + carry, with k = index.
  - The 4-bit result s is written to diff[4k+3:4k], carry is updated to c, and index increments.
  - When k = WIDTH/4-1: the state goes to DONE and, in the same edge, the block sets:
    - borrow = ~c
    - zero = (final diff == 0), including the nibble being written
    - ovf = (a_reg[MSB] != b_reg[MSB]) && (s[3] != a_reg[MSB])
    - out_valid = 1
- DONE:
  - out_valid = 1 and all result outputs are held stable.
  - On out_ready, clear out_valid and go to IDLE. in_ready is 1 from the following cycle.
  - If out_ready is low, the result is held indefinitely.
- Latency: out_valid rises exactly WIDTH/4 edges after the accepting edge (4 cycles for WIDTH=16).
- Throughput: at most one operation per WIDTH/4+2 cycles.
- Input changes on a and b after acceptance have no effect, because operands are registered.
- in_valid during RUN or DONE is ignored; the source must hold its request until in_ready.
- WIDTH=4 is the degenerate case: a single RUN cycle, latency 1.
- Arithmetic is modulo 2^WIDTH. 0 - 0 gives borrow=0, zero=1, ovf=0.
- diff, borrow, zero and ovf retain their last values in IDLE and are meaningful only while out_valid = 1.

Decomposition:
- Shared arithmetic package:
  - NIBBLE_W = 4
  - the state enum {IDLE, RUN, DONE}
  - an index-width function, ceil(log2(WIDTH/4)), minimum 1
- One natural sub-module, sub_slice4:
  - Combinational 4-bit a + ~b + cin.
  - Internal per-bit generate/propagate with lookahead carry.
  - Outputs s[3:0] and cout.
  - Instantiated once and reused every RUN cycle.

Test Plan:
- WIDTH=16: a=0x1234, b=0x0234 -> after 4 cycles diff=0x1000, borrow=0, zero=0, ovf=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, zero=0, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
- a=0x5A5A, b=0x5A5A -> diff=0x0000, zero=1, borrow=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
- Backpressure: result 0x1000 reached with out_ready=0 for 10 cycles.
  - out_valid stays 1 and diff stays stable.
  - in_ready stays 0; in_valid pulses with new operands are ignored.
  - out_ready=1 -> one-cycle handshake, then in_ready=1.
- Reset mid-RUN: assert rst_n=0 at the 2nd RUN edge -> next cycle state is IDLE, in_ready=1, out_valid=0, diff=0. A fresh 0x0003-0x0005 then yields diff=0xFFFE, borrow=1.
- WIDTH=4 build: a=0x3, b=0x5 -> out_valid 1 cycle after accept, diff=0xE, borrow=1, ovf=0. Then a=0x8, b=0x1 -> diff=0x7, ovf=1.
